// File: rtl/iic_slave_regfile.sv
// I2C slave fronting a 2**DEPTH_LOG2 byte register file, with a local write strobe and read port.
// Optional build macro IIC_SLV_GLITCH_FILTER_EN inserts a 3-sample majority filter on SCL and SDA.
module iic_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  busy,
    output logic                  wr_strobe,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [7:0]            wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_WDATA, S_RDATA, S_RACK, S_WAIT
    } state_t;

    logic [1:0]            r_scl_sync, r_sda_sync;
    logic                  r_scl_prev, r_sda_prev;
    logic                  w_scl, w_sda;
    logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
    state_t                r_state, w_state_nxt;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]            r_shift, w_shift_nxt;
    logic                  r_sda_oe, w_sda_oe_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_ack, w_ack_nxt;
    logic [DEPTH_LOG2-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic                  w_wr_en;
    logic [7:0]            r_regs [DEPTH];
    logic                  r_wr_strobe;
    logic [DEPTH_LOG2-1:0] r_wr_addr;
    logic [7:0]            r_wr_data, r_rd_data;

    // Two-flop synchronizers; the bus idles high so reset to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
        end
    end

`ifdef IIC_SLV_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist, r_sda_hist;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Sample history feeding the majority vote; a single-clock pulse never wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
        end
    end

    assign w_scl = maj3(r_scl_hist);
    assign w_sda = maj3(r_sda_hist);
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous-value registers for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_ptr_inc  = r_ptr + DEPTH_LOG2'(1);

    // Next-state logic; START/STOP outrank bit events in every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_ack_nxt     = r_ack;
        w_ptr_nxt     = r_ptr;
        w_wr_en       = 1'b0;
        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_ack_nxt     = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_ack_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise && !r_ack && (r_bit_cnt != 4'd8)) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_ack) begin
                        // End of our ACK clock: both REG and WDATA continue as data writes.
                        w_sda_oe_nxt  = 1'b0;
                        w_ack_nxt     = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_WDATA;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_state_nxt  = S_ADDR_ACK;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_sda_oe_nxt = 1'b1;
                            w_ack_nxt    = 1'b1;
                            if (r_state == S_REG) begin
                                w_ptr_nxt = r_shift[DEPTH_LOG2-1:0];
                            end else begin
                                w_wr_en   = 1'b1;
                                w_ptr_nxt = w_ptr_inc;
                            end
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (!r_shift[0]) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_REG;
                        end else begin
                            w_shift_nxt  = r_regs[r_ptr];
                            w_sda_oe_nxt = ~r_regs[r_ptr][7];
                            w_state_nxt  = S_RDATA;
                        end
                    end else begin
                        w_state_nxt = S_ADDR_ACK;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_RACK;
                    end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                        w_sda_oe_nxt = ~r_shift[6];
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                    end else begin
                        w_state_nxt = S_RDATA;
                    end
                end
                S_RACK: begin
                    // Pointer advances only when the master ACKs, so a NACKed last byte is re-read next time.
                    if (w_scl_rise && !r_ack) begin
                        if (!w_sda) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = r_regs[w_ptr_inc];
                            w_ack_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end else if (w_scl_fall && r_ack) begin
                        w_sda_oe_nxt  = ~r_shift[7];
                        w_ack_nxt     = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_RDATA;
                    end else begin
                        w_state_nxt = S_RACK;
                    end
                end
                S_WAIT:  w_state_nxt = S_WAIT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    // Register file, write strobe and local read port; a same-cycle read sees the old byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_rd_data   <= 8'h00;
        end else begin
            if (w_wr_en) begin
                r_regs[r_ptr] <= r_shift;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= r_shift;
            end
            r_wr_strobe <= w_wr_en;
            r_rd_data   <= r_regs[rd_addr];
        end
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_data   = r_rd_data;
endmodule

// File: tb/tb_iic_slave_regfile.sv
// Scoreboard bench for iic_slave_regfile: a bit-banged I2C master plus a byte model of the register file.
module tb_iic_slave_regfile;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset_n, scl_m, sda_m, sda_bus;
    logic [3:0] rd_addr;
    logic       sda_oe, busy, wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, rd_data;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] old;
    } wr_exp_t;

    wr_exp_t    exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_exp_t    mon_e;
    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         quiet_on = 1'b0;
    bit         quiet_viol = 1'b0;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    iic_slave_regfile #(.SLAVE_ADDR(7'h50), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        s = sda_bus;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        check_val(tag, s, exp_ack);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        send_byte(p, 1'b0, "reg_ack");
        m_ptr = p[3:0];
    endtask

    task automatic reg_write(input logic [7:0] d);
        exp_wr.push_back({m_ptr, d, m_regs[m_ptr]});
        m_regs[m_ptr] = d;
        send_byte(d, 1'b0, "wdata_ack");
        m_ptr = m_ptr + 4'd1;
    endtask

    task automatic read_byte_chk(input logic ack);
        logic [7:0] d;
        logic       s;
        exp_rd.push_back(m_regs[m_ptr]);
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(ack, s);
        check_val("rd_byte", d, exp_rd.pop_front());
        if (!ack) m_ptr = m_ptr + 4'd1;
    endtask

    task automatic local_read(input logic [3:0] idx, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = idx;
        @(negedge clk);
        check_val("rd_local", rd_data, exp);
    endtask

    // Write-strobe monitor: pops the expected write and checks same-cycle/next-cycle read behaviour.
    always @(negedge clk) begin
        if (reset_n && wr_strobe) begin
            if (exp_wr.size() == 0) begin
                check_val("wr_unexpected", 32'(wr_strobe), 32'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check_val("wr_addr", wr_addr, mon_e.addr);
                check_val("wr_data", wr_data, mon_e.data);
                if (rd_addr == mon_e.addr) begin
                    check_val("rd_old", rd_data, mon_e.old);
                    @(negedge clk);
                    check_val("rd_new", rd_data, mon_e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (quiet_on && (sda_oe || busy)) quiet_viol = 1'b1;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic s;
        reset_n = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        repeat (4) @(negedge clk);
        check_val("rst_sda_oe", sda_oe, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_wr_strobe", wr_strobe, 1'b0);
        check_val("rst_wr_addr", wr_addr, 4'd0);
        check_val("rst_wr_data", wr_data, 8'h00);
        check_val("rst_rd_data", rd_data, 8'h00);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        local_read(4'd0, 8'h00);

        // Preload a few registers so later reads are distinguishable.
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        check_val("busy_on_match", busy, 1'b1);
        set_ptr(8'h00);
        reg_write(8'h5E);
        reg_write(8'hC1);
        reg_write(8'hC2);
        reg_write(8'h7D);
        i2c_stop();
        check_val("busy_after_stop", busy, 1'b0);

        // Basic write with local read watching index 4 during the write.
        @(negedge clk);
        rd_addr = 4'd4;
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        set_ptr(8'h03);
        reg_write(8'h11);
        reg_write(8'h22);
        i2c_stop();
        local_read(4'd4, 8'h22);
        local_read(4'd3, 8'h11);

        // Pointer wrap, then a bare read to confirm the pointer landed on 1.
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        set_ptr(8'h0F);
        reg_write(8'hAA);
        reg_write(8'hBB);
        i2c_stop();
        local_read(4'd15, 8'hAA);
        local_read(4'd0, 8'hBB);
        i2c_start();
        send_byte(8'hA1, 1'b0, "addr_rd_ack");
        read_byte_chk(1'b1);
        i2c_stop();

        // Repeated-start read of three bytes, last one NACKed.
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        set_ptr(8'h02);
        i2c_rep_start();
        send_byte(8'hA1, 1'b0, "addr_rd_ack");
        read_byte_chk(1'b0);
        read_byte_chk(1'b0);
        read_byte_chk(1'b1);
        wait_q();
        check_val("nack_release", sda_oe, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, 1'b0, "addr_rd_ack");
        read_byte_chk(1'b1);
        i2c_stop();

        // Foreign address: slave must stay silent and leave the registers alone.
        quiet_on = 1'b1;
        i2c_start();
        send_byte(8'hA2, 1'b1, "nomatch_addr_ack");
        send_byte(8'h99, 1'b1, "nomatch_data_ack");
        i2c_stop();
        quiet_on = 1'b0;
        check_val("nomatch_quiet", quiet_viol, 1'b0);
        local_read(4'd2, m_regs[2]);
        local_read(4'd9, m_regs[9]);

        // Reset asserted mid-read while the slave is pulling SDA low.
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        set_ptr(8'h05);
        reg_write(8'h00);
        i2c_rep_start();
        send_byte(8'hA1, 1'b0, "addr_rd_ack");
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        check_val("rd_drive_oe", sda_oe, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("rst_async_oe", sda_oe, 1'b0);
        check_val("rst_async_busy", busy, 1'b0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        scl_m   = 1'b1;
        wait_q();
        wait_q();
        i2c_start();
        send_byte(8'hA0, 1'b0, "post_rst_addr_ack");
        check_val("post_rst_busy", busy, 1'b1);
        i2c_stop();
        local_read(4'd3, 8'h00);

`ifdef IIC_SLV_GLITCH_FILTER_EN
        // One-clock SCL low glitch inside a data bit must not shift an extra bit.
        i2c_start();
        send_byte(8'hA0, 1'b0, "addr_ack");
        set_ptr(8'h06);
        exp_wr.push_back({m_ptr, 8'h5A, m_regs[m_ptr]});
        m_regs[m_ptr] = 8'h5A;
        m_ptr = m_ptr + 4'd1;
        begin
            logic [7:0] gd;
            gd = 8'h5A;
            for (int i = 7; i >= 0; i--) begin
                if (i == 3) begin
                    sda_m = gd[i];
                    wait_q();
                    scl_m = 1'b1;
                    repeat (2) @(negedge clk);
                    scl_m = 1'b0;
                    @(negedge clk);
                    scl_m = 1'b1;
                    repeat (5) @(negedge clk);
                    scl_m = 1'b0;
                    wait_q();
                end else begin
                    clock_bit(gd[i], s);
                end
            end
            clock_bit(1'b1, s);
            check_val("glitch_ack", s, 1'b0);
        end
        i2c_stop();
        local_read(4'd6, 8'h5A);
`endif

        repeat (8) @(negedge clk);
        check_val("wr_queue_drained", exp_wr.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
